// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - Serialises IF/MEM 32-bit requests onto an 8-bit synchronous RAM bus.
module ram_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_interception,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [2:0]  r_n;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic        r_if_done;
    logic        r_mem_done;
    logic [31:0] r_if_inst;
    logic [31:0] r_mem_rdata;
    logic [31:0] r_ram_a;
    logic [7:0]  r_ram_dout;
    logic        r_ram_wr;

    logic [2:0]  w_mem_n;
    logic [2:0]  w_cnt_inc;
    logic [31:0] w_next_a;
    logic        w_last_rd;
    logic [1:0]  w_bi;
    logic [31:0] w_rd_word;
    logic [7:0]  w_wr_byte;

    assign w_mem_n   = (mem_len == 2'b00) ? 3'd1 : (mem_len == 2'b01) ? 3'd2 : 3'd4;
    assign w_cnt_inc = r_cnt + 3'd1;
    assign w_next_a  = r_addr + {29'd0, w_cnt_inc};
    assign w_last_rd = (r_cnt == r_n);
    assign w_bi      = r_cnt[1:0] - 2'd1;

    // r_cnt is the index of the address on the bus; the byte arriving now belongs to r_cnt-1.
    always_comb begin
        w_rd_word = r_buf;
        if (r_cnt != 3'd0) begin
            w_rd_word[{w_bi, 3'b000} +: 8] = ram_din;
        end
    end

    always_comb begin
        w_wr_byte = r_wdata[7:0];
        case (w_cnt_inc[1:0])
            2'd1:    w_wr_byte = r_wdata[15:8];
            2'd2:    w_wr_byte = r_wdata[23:16];
            2'd3:    w_wr_byte = r_wdata[31:24];
            default: w_wr_byte = r_wdata[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_n         <= 3'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_buf       <= 32'd0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_if_inst   <= 32'd0;
            r_mem_rdata <= 32'd0;
            r_ram_a     <= 32'd0;
            r_ram_dout  <= 8'd0;
            r_ram_wr    <= 1'b0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mem_req) begin
                        r_addr  <= mem_addr;
                        r_wdata <= mem_wdata;
                        r_n     <= w_mem_n;
                        r_cnt   <= 3'd0;
                        r_buf   <= 32'd0;
                        r_ram_a <= mem_addr;
                        if (mem_we) begin
                            r_ram_wr   <= 1'b1;
                            r_ram_dout <= mem_wdata[7:0];
                            r_state    <= MEM_WR;
                        end else begin
                            r_state <= MEM_RD;
                        end
                    end else if (if_req && !branch_interception) begin
                        r_addr  <= if_addr;
                        r_n     <= 3'd4;
                        r_cnt   <= 3'd0;
                        r_buf   <= 32'd0;
                        r_ram_a <= if_addr;
                        r_state <= IF_RD;
                    end
                end
                IF_RD, MEM_RD: begin
                    if (r_state == IF_RD && branch_interception) begin
                        r_ram_a <= 32'd0;
                        r_state <= IDLE;
                    end else begin
                        r_buf <= w_rd_word;
                        if (w_last_rd) begin
                            r_state <= DONE;
                            if (r_state == IF_RD) begin
                                r_if_done <= 1'b1;
                                r_if_inst <= w_rd_word;
                            end else begin
                                r_mem_done  <= 1'b1;
                                r_mem_rdata <= w_rd_word;
                            end
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            r_ram_a <= (w_cnt_inc < r_n) ? w_next_a : 32'd0;
                        end
                    end
                end
                MEM_WR: begin
                    if (w_cnt_inc == r_n) begin
                        r_ram_a    <= 32'd0;
                        r_ram_dout <= 8'd0;
                        r_ram_wr   <= 1'b0;
                        r_mem_done <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_cnt      <= w_cnt_inc;
                        r_ram_a    <= w_next_a;
                        r_ram_dout <= w_wr_byte;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // A flush landing on the DONE cycle must still suppress the fetch.
    assign if_done   = r_if_done & ~branch_interception;
    assign if_inst   = r_if_inst;
    assign mem_done  = r_mem_done;
    assign mem_rdata = r_mem_rdata;
    assign ram_a     = r_ram_a;
    assign ram_dout  = r_ram_dout;
    assign ram_wr    = r_ram_wr;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - Randomised self-checking bench for ram_arbiter against a byte-array model.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_interception;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  ram_mem [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] ref_inst  = 32'd0;
    logic [31:0] ref_rdata = 32'd0;
    bit          inst_known = 1'b1;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .branch_interception (branch_interception),
        .if_req              (if_req),
        .if_addr             (if_addr),
        .if_done             (if_done),
        .if_inst             (if_inst),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_len             (mem_len),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_done            (mem_done),
        .mem_rdata           (mem_rdata),
        .ram_din             (ram_din),
        .ram_dout            (ram_dout),
        .ram_a               (ram_a),
        .ram_wr              (ram_wr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // Little-endian word of n bytes from the reference memory, upper bytes zero.
    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w = 32'd0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = ref_rd(a + 32'(i));
        return w;
    endfunction

    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_a] = ram_dout;
        ram_din <= ram_rd(ram_a);
    end

    task automatic do_fetch(input logic [31:0] a, input int flush_k, input bit blocked);
        logic [31:0] e;
        e = ref_word(a, 4);
        @(negedge clk);
        branch_interception = blocked;
        mem_req = 1'b0;
        if_req  = 1'b1;
        if_addr = a;
        if (blocked) begin
            @(negedge clk);
            branch_interception = 1'b0;
            #1;
            check("if_blocked_a", ram_a, 32'd0);
            check("if_blocked_wr", {31'd0, ram_wr}, 32'd0);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            branch_interception = (k == flush_k);
            if (k == flush_k || k == 6) if_req = 1'b0;
            #1;
            if (flush_k > 0 && flush_k <= 5 && k > flush_k) begin
                check("flush_idle_a", ram_a, 32'd0);
            end else if (k <= 4) begin
                check("if_a", ram_a, a + 32'(k - 1));
                check("if_wr", {31'd0, ram_wr}, 32'd0);
            end
            if (k < 6) begin
                check("if_done_early", {31'd0, if_done}, 32'd0);
            end else if (flush_k > 0) begin
                check("if_done_flushed", {31'd0, if_done}, 32'd0);
            end else begin
                check("if_done", {31'd0, if_done}, 32'd1);
                check("if_inst", if_inst, e);
            end
        end
        if (flush_k == 0) begin
            ref_inst   = e;
            inst_known = 1'b1;
        end else if (flush_k == 6) begin
            inst_known = 1'b0;
        end else if (inst_known) begin
            check("if_inst_hold", if_inst, ref_inst);
        end
    endtask

    task automatic do_mem(input bit we, input logic [1:0] len, input logic [31:0] a,
                          input logic [31:0] wd, input bit noise);
        int n;
        int last;
        logic [31:0] e;
        n    = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        last = we ? n + 1 : n + 2;
        e    = ref_word(a, n);
        @(negedge clk);
        branch_interception = 1'b0;
        if_req    = 1'b0;
        mem_req   = 1'b1;
        mem_we    = we;
        mem_len   = len;
        mem_addr  = a;
        mem_wdata = wd;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (noise) branch_interception = 1'($urandom_range(0, 1));
            if (k == last) mem_req = 1'b0;
            #1;
            if (k <= n) begin
                check("mem_a", ram_a, a + 32'(k - 1));
                check("mem_wr", {31'd0, ram_wr}, {31'd0, we});
                if (we) check("mem_dout", {24'd0, ram_dout}, {24'd0, wd[8*(k-1) +: 8]});
            end
            if (k < last) begin
                check("mem_done_early", {31'd0, mem_done}, 32'd0);
            end else begin
                check("mem_done", {31'd0, mem_done}, 32'd1);
                check("mem_rdata", mem_rdata, we ? ref_rdata : e);
                check("mem_bus_idle", {31'd0, ram_wr}, 32'd0);
                check("mem_if_done", {31'd0, if_done}, 32'd0);
            end
        end
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
        end else begin
            ref_rdata = e;
        end
    endtask

    initial begin
        logic [7:0]  pre [4] = '{8'h13, 8'h05, 8'h10, 8'h00};
        logic [31:0] ra;
        int          op;
        int          r;

        rst = 1'b1;
        branch_interception = 1'b0;
        if_req = 1'b0;  if_addr = 32'd0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'd0; mem_wdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            ram_mem[32'h100 + 32'(i)] = pre[i];
            ref_mem[32'h100 + 32'(i)] = pre[i];
        end
        ram_mem[32'h200] = 8'hFF;
        ref_mem[32'h200] = 8'hFF;

        repeat (2) @(negedge clk);
        #1;
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_ram_a", ram_a, 32'd0);
        check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
        check("rst_done", {30'd0, if_done, mem_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_fetch(32'h100, 0, 1'b0);
        check("tp_fetch_word", if_inst, 32'h00100513);

        // Simultaneous IF and MEM requests: MEM first, IF granted right after.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h104;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h200;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3)  mem_req = 1'b0;
            if (k == 10) if_req = 1'b0;
            #1;
            if (k == 1) check("sim_mem_a", ram_a, 32'h200);
            if (k < 3)  check("sim_mem_done_early", {31'd0, mem_done}, 32'd0);
            if (k == 3) begin
                check("sim_mem_done", {31'd0, mem_done}, 32'd1);
                check("sim_mem_rdata", mem_rdata, 32'h000000FF);
            end
            if (k >= 5 && k <= 8) check("sim_if_a", ram_a, 32'h104 + 32'(k - 5));
            if (k < 10) check("sim_if_done_early", {31'd0, if_done}, 32'd0);
            else begin
                check("sim_if_done", {31'd0, if_done}, 32'd1);
                check("sim_if_inst", if_inst, ref_word(32'h104, 4));
            end
        end
        ref_rdata = 32'h000000FF;
        ref_inst  = ref_word(32'h104, 4);

        do_mem(1'b1, 2'b01, 32'h300, 32'hDEADBEEF, 1'b0);
        check("tp_no_302", {24'd0, ram_rd(32'h302)}, {24'd0, init_byte(32'h302)});
        do_mem(1'b0, 2'b11, 32'hFFFFFFFE, 32'd0, 1'b0);
        do_fetch(32'h100, 3, 1'b0);
        do_fetch(32'h100, 0, 1'b0);
        do_fetch(32'h100, 6, 1'b0);
        do_fetch(32'h104, 0, 1'b1);

        // Reset asserted mid-store, away from any address the bench reads later.
        @(negedge clk);
        branch_interception = 1'b0;
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b11;
        mem_addr = 32'h80000000; mem_wdata = $urandom;
        @(negedge clk);
        #1;
        check("rstmid_wr_before", {31'd0, ram_wr}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstmid_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rstmid_ram_a", ram_a, 32'd0);
        check("rstmid_ram_dout", {24'd0, ram_dout}, 32'd0);
        check("rstmid_if_inst", if_inst, 32'd0);
        check("rstmid_mem_rdata", mem_rdata, 32'd0);
        check("rstmid_done", {30'd0, if_done, mem_done}, 32'd0);
        mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ref_inst   = 32'd0;
        ref_rdata  = 32'd0;
        inst_known = 1'b1;
        do_fetch(32'h100, 0, 1'b0);

        for (int t = 0; t < 80; t++) begin
            op = $urandom_range(0, 2);
            ra = 32'h1000 + 32'($urandom_range(0, 63));
            if (op == 0) begin
                r = $urandom_range(0, 9);
                do_fetch(ra, (r > 6) ? 0 : r, 1'($urandom_range(0, 3) == 0));
            end else begin
                do_mem(op == 2, 2'($urandom_range(0, 3)), ra, $urandom, 1'($urandom_range(0, 1)));
            end
        end

        @(negedge clk);
        branch_interception = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
